pcileech_vfifo_in_arb: RTL and testbench

PCILEECH_VFIFO_IN_ARB -- requirements
Module: pcileech_vfifo_in_arb

---
 rtl/pcileech_vfifo_in_arb.sv | 117 +++++++++++
 tb/tb_pcileech_vfifo_in_arb.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcileech_vfifo_in_arb.sv
// Three-source round-robin packet arbiter feeding the virtual FIFO input.
// A granted source keeps the output until it sends a last beat or hits the
// per-grant beat limit; beats are forwarded one cycle after acceptance and
// at most every other cycle.
module pcileech_vfifo_in_arb #(
  parameter int unsigned MAX_BEATS = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [767:0] src_data,
  input  logic [2:0]   src_valid,
  input  logic [2:0]   src_last,
  output logic [2:0]   src_ready,
  output logic [255:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [1:0]   gnt_idx,
  output logic         busy
);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  // Beat count value at which the current beat is the final one of the grant.
  localparam logic [7:0] LAST_BEAT = 8'(MAX_BEATS - 1);

  state_t       state_q;
  logic [1:0]   gnt_idx_q;
  logic [7:0]   beat_cnt_q;
  logic         out_valid_q;
  logic [255:0] out_data_q;

  logic [1:0]   rr_first;
  logic [1:0]   rr_second;
  logic [1:0]   rr_winner;
  logic [2:0]   grant_oh;
  logic         accept;
  logic         accept_last;
  logic [255:0] sel_data;

  // Round-robin pick: start one past the previous grant and wrap modulo 3.
  always_comb begin
    // NOTE: every signal written here gets a value on every path first,
    // otherwise an unassigned path would infer a latch.
    rr_first  = (gnt_idx_q == 2'd2) ? 2'd0 : gnt_idx_q + 2'd1;
    rr_second = (rr_first == 2'd2) ? 2'd0 : rr_first + 2'd1;
    rr_winner = gnt_idx_q;
    if (src_valid[rr_first]) begin
      rr_winner = rr_first;
    end else if (src_valid[rr_second]) begin
      rr_winner = rr_second;
    end
  end

  // Handshake toward the sources and data select of the granted source.
  always_comb begin
    grant_oh  = 3'b001 << gnt_idx_q;
    src_ready = 3'b000;
    // Ready is held low while a beat is still on the output so beats are
    // spaced at least one idle cycle apart, and during reset so nothing
    // accepted in the reset cycle can be lost silently.
    if (!rst && (state_q == LOCK) && out_ready && !out_valid_q) begin
      src_ready = grant_oh;
    end
    accept      = |(src_valid & src_ready);
    accept_last = |(src_valid & src_ready & src_last);
    case (gnt_idx_q)
      2'd0:    sel_data = src_data[255:0];
      2'd1:    sel_data = src_data[511:256];
      default: sel_data = src_data[767:512];
    endcase
  end

  // Grant FSM with registered output beat, grant index and beat counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_idx_q   <= 2'd2;
      beat_cnt_q  <= 8'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every register
      // sees the pre-edge values of the others, independent of statement order.
      out_valid_q <= accept;
      if (accept) begin
        out_data_q <= sel_data;
      end
      case (state_q)
        IDLE: begin
          if (|src_valid) begin
            gnt_idx_q  <= rr_winner;
            beat_cnt_q <= 8'd0;
            state_q    <= LOCK;
          end
        end
        LOCK: begin
          if (accept) begin
            beat_cnt_q <= beat_cnt_q + 8'd1;
            if (accept_last || (beat_cnt_q == LAST_BEAT)) begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign gnt_idx   = gnt_idx_q;
  assign busy      = (state_q == LOCK);

endmodule

// File: tb/tb_pcileech_vfifo_in_arb.sv
// Self-checking bench: two arbiter instances (MAX_BEATS 64 and 3) share the
// same source stimulus; a per-instance reference model predicts every output
// each cycle and packet-level scoreboards check ordering, spacing and limits.
`timescale 1ns/1ps
module tb_pcileech_vfifo_in_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [767:0] src_data;
  logic [2:0]   src_valid;
  logic [2:0]   src_last;
  logic         out_ready;

  logic [2:0]   rdy [2];
  logic [255:0] od  [2];
  logic         ov  [2];
  logic [1:0]   gi  [2];
  logic         bz  [2];

  pcileech_vfifo_in_arb #(.MAX_BEATS(64)) dut (
    .clk(clk), .rst(rst), .src_data(src_data), .src_valid(src_valid),
    .src_last(src_last), .src_ready(rdy[0]), .out_data(od[0]),
    .out_valid(ov[0]), .out_ready(out_ready), .gnt_idx(gi[0]), .busy(bz[0])
  );

  pcileech_vfifo_in_arb #(.MAX_BEATS(3)) dut3 (
    .clk(clk), .rst(rst), .src_data(src_data), .src_valid(src_valid),
    .src_last(src_last), .src_ready(rdy[1]), .out_data(od[1]),
    .out_valid(ov[1]), .out_ready(out_ready), .gnt_idx(gi[1]), .busy(bz[1])
  );

  // Reference model state: which source holds the output, beats sent in
  // this grant, and the beat currently presented downstream.
  typedef struct {
    bit           lock;
    int           gnt;
    int           cnt;
    bit           ov;
    logic [255:0] od;
  } mdl_t;

  mdl_t m [2];
  int   mmax [2];

  // Per-source beat lists consumed in order.
  logic [255:0] pdata [3][256];
  bit           plast [3][256];
  int           phead [3];
  int           ptail [3];

  int  drv_sel;
  bit  gap_en;

  // Observations on the instance selected by drv_sel.
  logic [255:0] em [$];
  int           em_cyc [$];
  bit           em_busy [$];
  int           glog [$];

  bit         prev_ov [2];
  bit         prev_bz [2];
  logic [2:0] last_rdy [2];
  int         cyc;

  int checks;
  int failures;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Which source the model would accept from in the current cycle.
  function automatic logic [2:0] m_ready(input int k);
    if (rst || !m[k].lock || !out_ready || m[k].ov) return 3'b000;
    return 3'(1 << m[k].gnt);
  endfunction

  // Advance model k across one clock edge using the present inputs.
  task automatic model_step(input int k);
    logic [2:0] acc;
    acc = src_valid & m_ready(k);
    if (rst) begin
      m[k].lock = 1'b0;
      m[k].gnt  = 2;
      m[k].cnt  = 0;
      m[k].ov   = 1'b0;
      m[k].od   = '0;
      return;
    end
    m[k].ov = |acc;
    if (|acc) m[k].od = src_data[m[k].gnt*256 +: 256];
    if (!m[k].lock) begin
      if (|src_valid) begin
        for (int d = 1; d <= 3; d++) begin
          int c;
          c = (m[k].gnt + d) % 3;
          if (src_valid[c]) begin
            m[k].gnt = c;
            break;
          end
        end
        m[k].cnt  = 0;
        m[k].lock = 1'b1;
      end
    end else if (|acc) begin
      if (src_last[m[k].gnt] || (m[k].cnt == mmax[k] - 1)) m[k].lock = 1'b0;
      m[k].cnt = (m[k].cnt + 1) % 256;
    end
  endtask

  task automatic push_pkt(input int s, input int n);
    for (int b = 0; b < n; b++) begin
      pdata[s][ptail[s]] = rnd256();
      plast[s][ptail[s]] = (b == n - 1);
      ptail[s]++;
    end
  endtask

  function automatic bit pending();
    bit p;
    p = 1'b0;
    for (int s = 0; s < 3; s++) if (phead[s] != ptail[s]) p = 1'b1;
    return p;
  endfunction

  // Present each source's head beat; idle sources show junk data/last.
  task automatic drive();
    for (int s = 0; s < 3; s++) begin
      if (phead[s] < ptail[s]) begin
        src_data[s*256 +: 256] = pdata[s][phead[s]];
        src_last[s]  = plast[s][phead[s]];
        src_valid[s] = gap_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      end else begin
        src_data[s*256 +: 256] = rnd256();
        src_last[s]  = 1'($urandom_range(0, 1));
        src_valid[s] = 1'b0;
      end
    end
  endtask

  // One clock: drive at negedge, check ready, step models, check outputs.
  task automatic cycle();
    logic [2:0] acc;
    string      pfx;
    drive();
    #1;
    for (int k = 0; k < 2; k++) begin
      pfx = (k == 0) ? "d64" : "d3";
      last_rdy[k] = rdy[k];
      check({pfx, ".src_ready"}, 256'(rdy[k]), 256'(m_ready(k)));
    end
    acc = src_valid & m_ready(drv_sel);
    for (int s = 0; s < 3; s++) if (acc[s]) phead[s]++;
    for (int k = 0; k < 2; k++) model_step(k);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    for (int k = 0; k < 2; k++) begin
      pfx = (k == 0) ? "d64" : "d3";
      check({pfx, ".out_valid"}, 256'(ov[k]), 256'(m[k].ov));
      check({pfx, ".out_data"}, od[k], m[k].od);
      check({pfx, ".gnt_idx"}, 256'(gi[k]), 256'(m[k].gnt));
      check({pfx, ".busy"}, 256'(bz[k]), 256'(m[k].lock));
      check({pfx, ".ov_adjacent"}, 256'(ov[k] & prev_ov[k]), 256'(0));
    end
    if (ov[drv_sel]) begin
      em.push_back(od[drv_sel]);
      em_cyc.push_back(cyc);
      em_busy.push_back(bz[drv_sel]);
    end
    if (bz[drv_sel] && !prev_bz[drv_sel]) glog.push_back(int'(gi[drv_sel]));
    for (int k = 0; k < 2; k++) begin
      prev_ov[k] = ov[k];
      prev_bz[k] = bz[k];
    end
  endtask

  task automatic reset_dut();
    for (int s = 0; s < 3; s++) begin
      phead[s] = 0;
      ptail[s] = 0;
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    em.delete();
    em_cyc.delete();
    em_busy.delete();
    glog.delete();
  endtask

  task automatic run_drain(input int budget);
    int n;
    n = 0;
    while ((pending() || m[drv_sel].lock) && n < budget) begin
      cycle();
      n++;
    end
    check("drain_done", 256'(pending() || m[drv_sel].lock), 256'(0));
    cycle();
    cycle();
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    int total;
    checks    = 0;
    failures  = 0;
    cyc       = 0;
    mmax[0]   = 64;
    mmax[1]   = 3;
    drv_sel   = 0;
    gap_en    = 1'b0;
    rst       = 1'b1;
    out_ready = 1'b1;
    src_data  = '0;
    src_valid = 3'b000;
    src_last  = 3'b000;
    for (int k = 0; k < 2; k++) begin
      m[k].lock = 1'b0; m[k].gnt = 2; m[k].cnt = 0; m[k].ov = 1'b0; m[k].od = '0;
      prev_ov[k] = 1'b0; prev_bz[k] = 1'b0;
    end
    for (int s = 0; s < 3; s++) begin
      phead[s] = 0;
      ptail[s] = 0;
    end
    @(negedge clk);

    // Reset state
    reset_dut();
    check("rst.out_valid", 256'(ov[0]), 256'(0));
    check("rst.out_data", od[0], 256'(0));
    check("rst.gnt_idx", 256'(gi[0]), 256'(2));
    check("rst.busy", 256'(bz[0]), 256'(0));

    // Single 4-beat packet from source 0
    push_pkt(0, 4);
    run_drain(40);
    check("t1.beats", 256'(em.size()), 256'(4));
    for (int i = 0; i < em.size() && i < 4; i++) check("t1.data", em[i], pdata[0][i]);
    for (int i = 1; i < em_cyc.size() && i < 4; i++)
      check("t1.spacing", 256'(em_cyc[i] - em_cyc[i-1]), 256'(2));
    if (em_busy.size() >= 4) check("t1.busy_after_last", 256'(em_busy[3]), 256'(0));
    check("t1.busy_end", 256'(bz[0]), 256'(0));

    // All sources busy with 2-beat packets: grants rotate 0,1,2
    reset_dut();
    for (int r = 0; r < 2; r++) for (int s = 0; s < 3; s++) push_pkt(s, 2);
    run_drain(100);
    check("t2.grants", 256'(glog.size()), 256'(6));
    for (int i = 0; i < glog.size() && i < 6; i++) check("t2.order", 256'(glog[i]), 256'(i % 3));
    check("t2.beats", 256'(em.size()), 256'(12));

    // Downstream stall mid-packet
    reset_dut();
    push_pkt(0, 6);
    n = 0;
    while (em.size() < 2 && n < 40) begin
      cycle();
      n++;
    end
    check("t3.pre_stall", 256'(em.size()), 256'(2));
    out_ready = 1'b0;
    repeat (5) begin
      cycle();
      check("t3.stall_ready", 256'(last_rdy[0]), 256'(0));
      check("t3.stall_valid", 256'(ov[0]), 256'(0));
      check("t3.stall_busy", 256'(bz[0]), 256'(1));
    end
    out_ready = 1'b1;
    run_drain(60);
    check("t3.beats", 256'(em.size()), 256'(6));
    for (int i = 0; i < em.size() && i < 6; i++) check("t3.data", em[i], pdata[0][i]);

    // Beat limit on the MAX_BEATS=3 instance
    reset_dut();
    drv_sel = 1;
    push_pkt(1, 10);
    push_pkt(2, 2);
    run_drain(200);
    if (glog.size() >= 2) begin
      check("t4.first_grant", 256'(glog[0]), 256'(1));
      check("t4.second_grant", 256'(glog[1]), 256'(2));
    end else begin
      check("t4.grants", 256'(glog.size()), 256'(2));
    end
    check("t4.beats", 256'(em.size()), 256'(12));
    if (em.size() >= 5) begin
      for (int i = 0; i < 3; i++) check("t4.src1_data", em[i], pdata[1][i]);
      for (int i = 0; i < 2; i++) check("t4.src2_data", em[3+i], pdata[2][i]);
    end

    // Reset during beat 2 of a 4-beat packet
    reset_dut();
    drv_sel = 0;
    push_pkt(0, 4);
    n = 0;
    while (em.size() < 1 && n < 40) begin
      cycle();
      n++;
    end
    check("t5.first_beat", 256'(em.size()), 256'(1));
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("t5.rst_ready", 256'(last_rdy[0]), 256'(0));
    check("t5.rst_out_valid", 256'(ov[0]), 256'(0));
    check("t5.rst_out_data", od[0], 256'(0));
    check("t5.rst_busy", 256'(bz[0]), 256'(0));
    check("t5.rst_gnt", 256'(gi[0]), 256'(2));
    phead[0] = ptail[0];
    base = ptail[0];
    push_pkt(0, 2);
    cycle();
    check("t5.regrant_busy", 256'(bz[0]), 256'(1));
    check("t5.regrant_gnt", 256'(gi[0]), 256'(0));
    run_drain(40);
    check("t5.beats", 256'(em.size()), 256'(3));
    if (em.size() >= 3) begin
      check("t5.new_data0", em[1], pdata[0][base]);
      check("t5.new_data1", em[2], pdata[0][base+1]);
    end

    // Randomized traffic with gaps and backpressure
    reset_dut();
    drv_sel = 0;
    gap_en  = 1'b1;
    total   = 0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        int s;
        int len;
        s   = int'($urandom_range(0, 2));
        len = int'($urandom_range(1, 5));
        if (ptail[s] + len <= 256) begin
          push_pkt(s, len);
          total += len;
        end
      end
      out_ready = ($urandom_range(0, 4) != 0);
      cycle();
    end
    out_ready = 1'b1;
    run_drain(600);
    check("rand.beats", 256'(em.size()), 256'(total));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
